fm_discriminator: RTL and testbench

Parametrised multi-channel FM phase discriminator for the receive chain. It sits directly after the CORDIC, consumes its AXI-Stream phase output, and computes the wrap-corrected sample-to-sample phase difference per channel. The differences are integrated over `DECIM` frames and dumped, then scaled and saturated. The result is emitted as a signed 16-bit audio-rate sample stream.

---
 rtl/fm_discriminator.sv | 134 +++++++++++++
 tb/tb_fm_discriminator.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_discriminator.sv
// Multi-channel FM phase discriminator.
// Takes interleaved CORDIC phase beats, forms the wrap-corrected phase
// difference per channel, integrates it over DECIM frames, then shifts,
// saturates and emits one signed 16-bit sample per channel per dump.
module fm_discriminator #(
  parameter int PHASE_WIDTH            = 16,
  parameter int NUM_CHANNELS           = 1,
  parameter int DECIM                  = 1,
  parameter int OUT_SHIFT              = 0,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  sat_pulse,
  output logic                                  frame_err
);

  localparam int PW    = PHASE_WIDTH;
  localparam int AW    = PHASE_WIDTH + 8;
  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int NSLOT = 1 << CW;

  localparam logic signed [AW-1:0] Y_MAX = AW'(32767);
  localparam logic signed [AW-1:0] Y_MIN = AW'(-32768);

  // The reset input is active-high despite its name.
  logic rst;
  logic clk;
  assign rst = s00_axis_aresetn;
  assign clk = s00_axis_aclk;

  // Magnitude half of the input word and the strobes carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axis_tdata, s00_axis_tstrb};

  // Per-channel state; slots above NUM_CHANNELS-1 are never addressed.
  logic [PW-1:0]        prev   [NSLOT];
  logic signed [AW-1:0] acc    [NSLOT];
  logic [NSLOT-1:0]     primed;
  logic [CW-1:0]        ch;
  logic [DW-1:0]        dcnt;
  logic [15:0]          y_q;

  logic                 accept;
  logic                 last_ch;
  logic                 dump;
  logic [PW-1:0]        phase;
  logic [PW-1:0]        diff;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [15:0]          y_next;

  // Handshake: a beat moves on either side only on a clock edge where valid
  // and ready are both high. The output register is a single stage, so the
  // input is ready whenever that stage is empty or being drained this cycle;
  // a held output keeps data, last and valid frozen until it is taken.
  assign s00_axis_tready = m00_axis_tready || !m00_axis_tvalid;
  assign accept          = s00_axis_tvalid && s00_axis_tready;

  assign phase   = s00_axis_tdata[16 +: PW];
  assign last_ch = (ch == CW'(NUM_CHANNELS - 1));
  assign dump    = (dcnt == DW'(DECIM - 1));

  // Difference modulo a full turn, integration and output scaling.
  always_comb begin
    diff    = primed[ch] ? (phase - prev[ch]) : '0;
    sum     = acc[ch] + {{8{diff[PW-1]}}, diff};
    shifted = sum >>> OUT_SHIFT;
    sat_hi  = (shifted > Y_MAX);
    sat_lo  = (shifted < Y_MIN);
    if (sat_hi)      y_next = 16'h7FFF;
    else if (sat_lo) y_next = 16'h8000;
    else             y_next = shifted[15:0];
  end

  // Channel sequencing, decimation count and per-channel phase/accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch     <= '0;
      dcnt   <= '0;
      primed <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        prev[i] <= '0;
        acc[i]  <= '0;
      end
    end else if (accept) begin
      prev[ch]   <= phase;
      primed[ch] <= 1'b1;
      acc[ch]    <= dump ? '0 : sum;
      if (last_ch) dcnt <= dump ? '0 : dcnt + 1'b1;
      // tlast resynchronises the channel counter to the frame start.
      ch <= (s00_axis_tlast || last_ch) ? '0 : ch + 1'b1;
    end
  end

  // Output register plus the saturation and framing status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      y_q             <= '0;
      sat_pulse       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      sat_pulse <= accept && dump && (sat_hi || sat_lo);
      frame_err <= accept && s00_axis_tlast && !last_ch;
      if (accept && dump) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tlast  <= last_ch;
        y_q             <= y_next;
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
    end
  end

  assign m00_axis_tdata = {{(C_M00_AXIS_TDATA_WIDTH - 16){y_q[15]}}, y_q};
  assign m00_axis_tstrb = {(C_M00_AXIS_TDATA_WIDTH / 8){1'b1}};

endmodule

// File: tb/tb_fm_discriminator.sv
// Bench for fm_discriminator: five instances with different channel,
// decimation and shift settings share one clock and reset. Directed table
// vectors carry hand-derived expectations; random traffic is scored against
// an integer model of the discriminator.
`timescale 1ns/1ps
module tb_fm_discriminator;

  localparam int NI = 5;

  function automatic int nch_of(input int g);
    case (g)
      1: return 2;
      4: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int dec_of(input int g);
    return (g == 2 || g == 3) ? 4 : 1;
  endfunction

  function automatic int sh_of(input int g);
    return (g == 3) ? 2 : 0;
  endfunction

  typedef struct {
    int          k;
    logic [15:0] phase;
    bit          last;
    bit          emit;
    logic [15:0] y;
    bit          ylast;
    bit          ysat;
    bit          yferr;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI-1:0]   s_valid;
  logic [NI-1:0]   s_last;
  logic [NI-1:0]   m_ready;
  logic [31:0]     s_data  [NI];
  logic [3:0]      s_strb;
  logic            s_ready [NI];
  logic            m_valid [NI];
  logic            m_last  [NI];
  logic [31:0]     m_data  [NI];
  logic [3:0]      m_strb  [NI];
  logic            sat     [NI];
  logic            ferr    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fm_discriminator #(
      .PHASE_WIDTH(16),
      .NUM_CHANNELS(nch_of(g)),
      .DECIM(dec_of(g)),
      .OUT_SHIFT(sh_of(g)),
      .C_S00_AXIS_TDATA_WIDTH(32),
      .C_M00_AXIS_TDATA_WIDTH(32)
    ) u_dut (
      .s00_axis_aclk(clk),
      .s00_axis_aresetn(rst),
      .s00_axis_tvalid(s_valid[g]),
      .s00_axis_tlast(s_last[g]),
      .s00_axis_tdata(s_data[g]),
      .s00_axis_tstrb(s_strb),
      .s00_axis_tready(s_ready[g]),
      .m00_axis_tready(m_ready[g]),
      .m00_axis_tvalid(m_valid[g]),
      .m00_axis_tlast(m_last[g]),
      .m00_axis_tdata(m_data[g]),
      .m00_axis_tstrb(m_strb[g]),
      .sat_pulse(sat[g]),
      .frame_err(ferr[g])
    );
  end

  // Reference model state
  int          md_ch     [NI];
  int          md_dcnt   [NI];
  int          md_prev   [NI][8];
  bit          md_primed [NI][8];
  longint      md_acc    [NI][8];

  // Scoreboard
  logic [32:0] exp_q [NI][$];
  int          exp_sat_cyc  [NI];
  int          exp_ferr_cyc [NI];
  int          cyc;
  int          n_vec;
  int          n_err;
  bit          done;
  bit          rand_ready;
  bit          hold_v [NI];
  bit          hold_l [NI];
  logic [31:0] hold_d [NI];
  vec_t        tbl[$];
  vec_t        vz;
  logic [15:0] rph [NI];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input logic [15:0] ph, input bit last, input bit emit,
                              input logic [15:0] y, input bit yl, input bit ys, input bit yf);
    vec_t v;
    v.k = k; v.phase = ph; v.last = last; v.emit = emit;
    v.y = y; v.ylast = yl; v.ysat = ys; v.yferr = yf;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      md_ch[k] = 0;
      md_dcnt[k] = 0;
      for (int c = 0; c < 8; c++) begin
        md_prev[k][c] = 0;
        md_primed[k][c] = 0;
        md_acc[k][c] = 0;
      end
      exp_q[k].delete();
      exp_sat_cyc[k] = -1;
      exp_ferr_cyc[k] = -1;
    end
  endtask

  // One accepted beat through the behavioural discriminator.
  task automatic model_step(input int k, input int ph, input bit last,
                            output bit emit, output logic [31:0] y32,
                            output bit ylast, output bit ysat, output bit yferr);
    int c, d, nch, dec;
    longint s, y;
    nch = nch_of(k);
    dec = dec_of(k);
    c = md_ch[k];
    d = (ph - md_prev[k][c]) & 'hFFFF;
    if (d > 32767) d = d - 65536;
    if (!md_primed[k][c]) d = 0;
    md_primed[k][c] = 1;
    md_prev[k][c] = ph;
    s = md_acc[k][c] + longint'(d);
    emit = (md_dcnt[k] == dec - 1);
    y = s >>> sh_of(k);
    ysat = 0;
    if (y > 32767) begin y = 32767; ysat = 1; end
    else if (y < -32768) begin y = -32768; ysat = 1; end
    y32 = y[31:0];
    md_acc[k][c] = emit ? 0 : s;
    ylast = (c == nch - 1);
    yferr = last && (c != nch - 1);
    if (c == nch - 1) md_dcnt[k] = emit ? 0 : md_dcnt[k] + 1;
    md_ch[k] = (last || c == nch - 1) ? 0 : c + 1;
  endtask

  // Present one beat to instance k and hold it until accepted.
  task automatic drive(input int k, input logic [15:0] ph, input bit last, input bit use_tbl, input vec_t v);
    bit ok, emit, ylast, ysat, yferr;
    logic [31:0] y32;
    int waited;
    ok = 0;
    waited = 0;
    s_valid[k] = 1'b1;
    s_last[k]  = last;
    s_data[k]  = {ph, 16'($urandom)};
    while (!ok) begin
      @(negedge clk);
      if (s_ready[k]) begin
        model_step(k, int'(ph), last, emit, y32, ylast, ysat, yferr);
        if (use_tbl) begin
          emit = v.emit; y32 = {{16{v.y[15]}}, v.y};
          ylast = v.ylast; ysat = v.ysat; yferr = v.yferr;
        end
        if (emit) exp_q[k].push_back({ylast, y32});
        if (emit && ysat) exp_sat_cyc[k] = cyc + 1;
        if (yferr) exp_ferr_cyc[k] = cyc + 1;
        ok = 1;
      end
      @(posedge clk);
      #1;
      if (!ok) begin
        waited++;
        if (waited > 50) begin
          n_vec++;
          n_err++;
          $display("FAIL accept_timeout inst%0d: got no tready expected acceptance", k);
          ok = 1;
        end
      end
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk(name, k, exp_q[k].size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = '0;
    s_last = '0;
    m_ready = '1;
    s_strb = 4'hF;
    for (int k = 0; k < NI; k++) begin
      s_data[k] = '0;
      hold_v[k] = 0;
      rph[k] = '0;
    end
    cyc = 0; n_vec = 0; n_err = 0; done = 0; rand_ready = 0;
    model_reset();

    // Directed vectors: {instance, phase, tlast} -> {emit, y, tlast, sat, frame_err}
    tbl.push_back(mk(0, 16'h1000, 1, 1, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 16'h1400, 1, 1, 16'h0400, 1, 0, 0));
    tbl.push_back(mk(0, 16'hFF00, 1, 1, 16'hEB00, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0100, 1, 1, 16'h0200, 1, 0, 0));
    tbl.push_back(mk(0, 16'hFF00, 1, 1, 16'hFE00, 1, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 16'h8000, 1, 1, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h7FF0, 1, 1, 16'hFFF0, 1, 0, 0));
    for (int k = 2; k <= 3; k++) begin
      tbl.push_back(mk(k, 16'h0000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'h7000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'hE000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'h5000, 1, 1, (k == 2) ? 16'h7FFF : 16'h5400, 1, k == 2, 0));
      tbl.push_back(mk(k, 16'hC000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'h3000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'hA000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'h1000, 1, 1, (k == 2) ? 16'h7FFF : 16'h7000, 1, k == 2, 0));
      tbl.push_back(mk(k, 16'hA000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'h3000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'hC000, 1, 0, 16'h0000, 1, 0, 0));
      tbl.push_back(mk(k, 16'h5000, 1, 1, (k == 2) ? 16'h8000 : 16'h9000, 1, k == 2, 0));
    end
    tbl.push_back(mk(4, 16'h0100, 0, 1, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(4, 16'h0200, 1, 1, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(4, 16'h0500, 0, 1, 16'h0400, 0, 0, 0));
    tbl.push_back(mk(4, 16'h0300, 0, 1, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(4, 16'h0000, 0, 1, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(4, 16'h0000, 1, 1, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(4, 16'h0510, 0, 1, 16'h0010, 0, 0, 0));

    fork
      begin : seq
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
          chk("rst_tvalid", k, m_valid[k], 0);
          chk("rst_tlast", k, m_last[k], 0);
          chk("rst_tdata", k, m_data[k], 0);
          chk("rst_sat", k, sat[k], 0);
          chk("rst_ferr", k, ferr[k], 0);
          chk("rst_tready", k, s_ready[k], 1);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i].k, tbl[i].phase, tbl[i].last, 1'b1, tbl[i]);
        drain_and_check("table_leftover");

        // Five cycles of downstream stall in the middle of a 16-sample ramp.
        fork
          begin
            for (int i = 0; i < 16; i++) drive(0, 16'(i * 256), 1'b1, 1'b0, vz);
          end
          begin
            repeat (4) @(posedge clk);
            #1;
            m_ready[0] = 1'b0;
            repeat (2) @(posedge clk);
            #3;
            chk("bp_tready_low", 0, s_ready[0], 0);
            chk("bp_tvalid_held", 0, m_valid[0], 1);
            repeat (3) @(posedge clk);
            #1;
            m_ready[0] = 1'b1;
          end
        join
        drain_and_check("ramp_leftover");

        // Random traffic with random downstream readiness.
        rand_ready = 1;
        for (int k = 0; k < NI; k++) begin
          for (int n = 0; n < 120; n++) begin
            int step;
            bit lastb;
            if ($urandom_range(0, 3) == 0) step = int'($urandom_range(0, 65535));
            else step = int'($urandom_range(0, 2047)) - 1024;
            rph[k] = rph[k] + 16'(step);
            lastb = (md_ch[k] == nch_of(k) - 1);
            if ($urandom_range(0, 15) == 0) lastb = !lastb;
            drive(k, rph[k], lastb, 1'b0, vz);
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
          end
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        m_ready = '1;
        drain_and_check("random_leftover");

        // Reset asserted between edges with a beat sitting in the output register.
        drive(1, 16'h1234, 1'b0, 1'b0, vz);
        #2;
        chk("pre_rst_tvalid", 1, m_valid[1], 1);
        rst = 1'b1;
        #1;
        chk("async_rst_tvalid", 1, m_valid[1], 0);
        chk("async_rst_tdata", 1, m_data[1], 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 16'h9999, 1'b0, 1'b0, vz);
        drive(1, 16'h9990, 1'b1, 1'b0, vz);
        drive(1, 16'h99A0, 1'b0, 1'b0, vz);
        drive(1, 16'h9980, 1'b1, 1'b0, vz);
        drain_and_check("post_rst_leftover");
        done = 1;
      end

      begin : monitor
        while (!done) begin
          @(posedge clk);
          cyc++;
          #2;
          if (cyc > 30000) begin
            n_err++;
            $display("FAIL watchdog: got %0d cycles expected under 30000", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "bench stalled");
          end
          if (rst) begin
            for (int k = 0; k < NI; k++) hold_v[k] = 0;
          end else begin
            for (int k = 0; k < NI; k++) begin
              logic [32:0] e;
              chk("ready_rule", k, s_ready[k], m_ready[k] || !m_valid[k]);
              chk("tstrb", k, m_strb[k], 4'hF);
              if (hold_v[k]) begin
                chk("hold_tvalid", k, m_valid[k], 1);
                chk("hold_tdata", k, m_data[k], hold_d[k]);
                chk("hold_tlast", k, m_last[k], hold_l[k]);
              end
              hold_v[k] = m_valid[k] && !m_ready[k];
              hold_d[k] = m_data[k];
              hold_l[k] = m_last[k];
              chk("sat_pulse", k, sat[k], exp_sat_cyc[k] == cyc);
              chk("frame_err", k, ferr[k], exp_ferr_cyc[k] == cyc);
              if (m_valid[k] && m_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                  chk("unexpected_out", k, m_data[k], 33'h1_0000_0000);
                end else begin
                  e = exp_q[k].pop_front();
                  chk("out_tdata", k, m_data[k], e[31:0]);
                  chk("out_tlast", k, m_last[k], e[32]);
                end
              end
            end
          end
        end
      end

      begin : ready_gen
        while (!done) begin
          @(posedge clk);
          #1;
          if (rand_ready) begin
            for (int k = 0; k < NI; k++) m_ready[k] = ($urandom_range(0, 3) != 0);
          end
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
